// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller beside ID: tracks in-flight writers in a
// shadow pipeline and derives per-port forward selects, stall, flag forward and a stall count.
module fwd_hazard_unit #(
  parameter int NPORTS   = 3,
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [AW-1:0]          id_dest,
  input  logic                   id_regwrite,
  input  logic                   id_isload,
  input  logic                   id_setflags,
  input  logic                   id_useflags,
  input  logic [NPORTS*AW-1:0]   rd_addr,
  input  logic [NPORTS-1:0]      rd_used,
  input  logic                   flush,
  output logic [NPORTS*SELW-1:0] fwd_sel,
  output logic                   stall,
  output logic                   flag_fwd,
  output logic [15:0]            stall_cycles
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dest;
    logic          regwrite;
    logic          isload;
    logic          setflags;
  } entry_t;

  // Index k is the number of stages past ID (1 = EX).
  entry_t stage_q [1:DEPTH];
  entry_t stage_d [1:DEPTH];

  logic [15:0]             cnt_q, cnt_d;
  logic [NPORTS*SELW-1:0]  sel_c;
  logic [NPORTS-1:0]       port_ld;
  logic                    hazard;
  logic                    issue;

  function automatic logic entry_match(input entry_t e, input logic [AW-1:0] addr,
                                       input logic used);
    return e.valid && e.regwrite && used && (e.dest == addr) && (e.dest != AW'(ZERO_REG));
  endfunction

  // Scan oldest to youngest so the youngest matching writer overwrites older ones.
  always_comb begin
    sel_c   = '0;
    port_ld = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (entry_match(stage_q[k], rd_addr[p*AW +: AW], rd_used[p])) begin
          sel_c[p*SELW +: SELW] = SELW'(k);
          port_ld[p]            = stage_q[k].isload && (k <= LOAD_LAT);
        end
      end
    end
    hazard = |port_ld;
  end

  assign fwd_sel  = reset ? '0 : sel_c;
  assign stall    = !reset && hazard && id_valid && !flush;
  // The youngest valid flag setter sits at stage 1 exactly when stage 1 holds a setter.
  assign flag_fwd = !reset && id_valid && id_useflags && stage_q[1].valid && stage_q[1].setflags;
  assign issue    = id_valid && !stall && !flush;

  always_comb begin
    stage_d[1] = '0;
    if (issue) begin
      stage_d[1].valid    = 1'b1;
      stage_d[1].dest     = id_dest;
      stage_d[1].regwrite = id_regwrite;
      stage_d[1].isload   = id_isload;
      stage_d[1].setflags = id_setflags;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expected {fwd_sel, stall, flag_fwd} vectors are
// queued as each ID cycle is driven and compared at the following falling edge.
module tb_fwd_hazard_unit;

  localparam int NPORTS = 3;
  localparam int AW     = 5;
  localparam int SELW   = 2;
  localparam int OW     = NPORTS*SELW + 2;

  logic                   clk;
  logic                   reset;
  logic                   id_valid;
  logic [AW-1:0]          id_dest;
  logic                   id_regwrite;
  logic                   id_isload;
  logic                   id_setflags;
  logic                   id_useflags;
  logic [NPORTS*AW-1:0]   rd_addr;
  logic [NPORTS-1:0]      rd_used;
  logic                   flush;
  logic [NPORTS*SELW-1:0] fwd_sel;
  logic                   stall;
  logic                   flag_fwd;
  logic [15:0]            stall_cycles;

  logic [OW-1:0] exp_q[$];
  int n_vec;
  int n_err;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_isload(id_isload), .id_setflags(id_setflags),
    .id_useflags(id_useflags), .rd_addr(rd_addr), .rd_used(rd_used), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .flag_fwd(flag_fwd), .stall_cycles(stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [AW-1:0] dest, input logic rw,
                       input logic ld, input logic sf, input logic uf,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [2:0] used, input logic fl);
    id_valid    = v;
    id_dest     = dest;
    id_regwrite = rw;
    id_isload   = ld;
    id_setflags = sf;
    id_useflags = uf;
    rd_addr     = {a2, a1, a0};
    rd_used     = used;
    flush       = fl;
  endtask

  task automatic push_exp(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                          input logic st, input logic ff);
    exp_q.push_back({s2, s1, s0, st, ff});
  endtask

  // Compare the oldest queued expectation against the DUT at the falling edge.
  task automatic sample(input string tag);
    logic [OW-1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {fwd_sel, stall, flag_fwd}, e);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                      input logic [1:0] s2, input logic st, input logic ff);
    push_exp(s0, s1, s2, st, ff);
    sample(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      step("idle", 0, 0, 0, 0, 0);
    end
  endtask

  logic [AW-1:0] rx;
  logic [AW-1:0] ry;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    chk("reset_sel", {26'd0, fwd_sel}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_cnt", {16'd0, stall_cycles}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // ALU chain: writer then held reader walks stages 1,2,3 then register file
    rx = AW'($urandom_range(0, 30));
    drive(1, rx, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    step("alu_issue", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, rx, 0, 0, 3'b001, 0);
    step("alu_k1", 1, 0, 0, 0, 0);
    step("alu_k2", 2, 0, 0, 0, 0);
    step("alu_k3", 3, 0, 0, 0, 0);
    step("alu_rf", 0, 0, 0, 0, 0);
    idle(3);

    // Load-use on port 1: one stall cycle, then forward from stage 2
    ry = AW'($urandom_range(0, 30));
    drive(1, ry, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    step("ld_issue", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, ry, 0, 3'b010, 0);
    step("ld_stall", 0, 1, 0, 1, 0);
    chk("ld_cnt", {16'd0, stall_cycles}, 32'd1);
    step("ld_fwd2", 0, 2, 0, 0, 0);
    idle(3);

    // Youngest of two writers wins
    drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    step("pri_w1", 0, 0, 0, 0, 0);
    step("pri_w2", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 5'd7, 0, 0, 3'b001, 0);
    step("pri_rd", 1, 0, 0, 0, 0);
    idle(3);

    // Zero register never forwards
    drive(1, 5'd31, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    step("x31_w", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 5'd31, 5'd31, 5'd31, 3'b111, 0);
    step("x31_rd", 0, 0, 0, 0, 0);
    idle(3);

    // Unused port ignores a matching writer
    drive(1, 5'd9, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    step("used_w", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 5'd9, 0, 5'd9, 3'b001, 0);
    step("used_rd", 1, 0, 0, 0, 0);
    idle(3);
    drive(1, 5'd9, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    step("used_ld", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 5'd9, 3'b000, 0);
    step("used_nostall", 0, 0, 0, 0, 0);
    idle(3);

    // Flags: setter directly ahead forwards, one bubble apart does not
    drive(1, 5'd31, 1, 0, 1, 0, 0, 0, 0, 3'b000, 0);
    step("flg_subs", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    step("flg_fwd", 0, 0, 0, 0, 1);
    idle(3);
    drive(1, 5'd31, 1, 0, 1, 0, 0, 0, 0, 3'b000, 0);
    step("flg_subs2", 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    step("flg_late", 0, 0, 0, 0, 0);
    idle(3);

    // Flush beats hazard; the killed writer never enters the pipeline
    drive(1, 5'd12, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    step("fl_ld", 0, 0, 0, 0, 0);
    drive(1, 5'd13, 1, 0, 0, 0, 5'd12, 0, 0, 3'b001, 1);
    step("fl_hz", 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 5'd12, 5'd13, 0, 3'b011, 0);
    step("fl_after", 2, 0, 0, 0, 0);
    chk("fl_cnt", {16'd0, stall_cycles}, 32'd1);
    idle(3);

    // Reset asserted mid-stall clears outputs and counter without a clock edge
    drive(1, 5'd20, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    step("rs_ld", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 5'd20, 5'd20, 0, 3'b011, 0);
    push_exp(1, 1, 0, 1, 0);
    sample("rs_stall");
    #1 reset = 1'b1;
    #1;
    chk("rs_async_stall", {31'd0, stall}, 32'd0);
    chk("rs_async_sel", {26'd0, fwd_sel}, 32'd0);
    chk("rs_async_cnt", {16'd0, stall_cycles}, 32'd0);
    @(posedge clk);
    #1;
    chk("rs_held_cnt", {16'd0, stall_cycles}, 32'd0);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 5'd20, 5'd20, 0, 3'b011, 0);
    step("rs_after", 0, 0, 0, 0, 0);
    idle(1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the pipelined CPU, sitting beside the ID stage. It keeps its own shadow pipeline of in-flight writers (EX, MEM, WB, …). Each cycle it produces:
- a forwarding select for each of NPORTS register read ports,
- a load-use stall,
- a flag-forward signal for conditional branches,
- a saturating stall-cycle counter.

Unlike the fixed two-stage forwarding logic it replaces, it has configurable depth, port count and load latency. It also tracks writers internally, so the surrounding stages do not have to feed it their write addresses.

## Interface
Parameters:
- NPORTS, 3, number of register read ports checked.
- DEPTH, 3, tracked stages after ID (stage 1 = EX, 2 = MEM, 3 = WB).
- AW, 5, register address width.
- ZERO_REG, 31, register that is never forwarded.
- LOAD_LAT, 1, a load in stage k ≤ LOAD_LAT cannot forward yet; its result is first forwardable at stage LOAD_LAT+1.
- SELW, $clog2(DEPTH+1), width of each select field.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_dest  in  AW  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes id_dest.
- id_isload  in  1  ID instruction is a load.
- id_setflags  in  1  ID instruction sets flags.
- id_useflags  in  1  ID instruction is a flag-conditional branch.
- rd_addr  in  NPORTS*AW  read addresses; port p occupies bits [p*AW +: AW].
- rd_used  in  NPORTS  port p is actually read. Set it to 0 for immediate, MOVK or ALUSrc operands.
- flush  in  1  kill the ID instruction (taken branch).
- fwd_sel  out  NPORTS*SELW  per port: 0 = register file, k = stage k.
- stall  out  1  hold PC and IF/ID, and insert a bubble.
- flag_fwd  out  1  take flags from the EX ALU instead of the flag register.
- stall_cycles  out  16  saturating count of stalled cycles.

## Operation
- **Shadow pipeline.** Entries stage[1..DEPTH] each hold {valid, dest, regwrite, isload, setflags}.
- **Advance every cycle (no enable):**
  - stage[k+1] ← stage[k].
  - stage[1] ← the ID fields with valid = 1 when id_valid & !stall & !flush.
  - Otherwise stage[1] ← bubble (valid = 0).
  - The entry in stage[DEPTH] retires.
- **Match.** Entry k matches port p when all of the following hold: valid, regwrite, dest == rd_addr[p], dest != ZERO_REG, and rd_used[p].
- **fwd_sel[p].** The smallest matching k (the youngest writer wins); 0 if no entry matches.
- **Load-use hazard.** The youngest match for any port has isload = 1 and k ≤ LOAD_LAT. Older matches behind a younger non-load match do not cause a hazard.
- **stall** = hazard & id_valid & !flush.
- **flag_fwd** = id_valid & id_useflags & (the youngest valid entry with setflags = 1 is at stage 1). If the youngest flag setter is at stage > 1, its flags are already committed and flag_fwd = 0.
- **stall_cycles** increments on every cycle with stall = 1 and saturates at 16'hFFFF.
- **Flush and hazard together.** Flush wins: stall = 0 and a bubble enters stage 1.
- **Reset (asynchronous).**
  - All entries are invalid and stall_cycles = 0.
  - fwd_sel = 0, stall = 0 and flag_fwd = 0 for as long as reset is held.
  - Reset asserted mid-stall drops the stall immediately.

## Timing
- fwd_sel, stall and flag_fwd are combinational from the registered entries plus the current ID inputs, valid in the same cycle.
- stall_cycles is registered and updates on the clock edge after the stalled cycle.
- An instruction issued at edge n is visible at stage k during cycle n+k. It can be forwarded through cycle n+DEPTH and reads the register file afterwards.
- With LOAD_LAT = L, a dependent instruction immediately after a load stalls L cycles. On the first non-stalled cycle, fwd_sel = L+1.
- During stall, fwd_sel still reports the match. Downstream logic ignores it because a bubble is issued.

## Test plan
- **ALU chain, defaults.**
  - Stimulus: issue ADD with dest X5 at edge 0, then hold ID reading X5 on port 0.
  - Required: fwd_sel[0] = 1, 2, 3, 0 in cycles 1–4; stall = 0 throughout.
- **Load-use.**
  - Stimulus: issue LDUR with dest X3, then the next instruction reads X3 on port 1.
  - Required: stall = 1 with fwd_sel[1] = 1 for one cycle. Next cycle stall = 0 and fwd_sel[1] = 2. stall_cycles = 1.
- **Priority and X31.**
  - Stimulus: two back-to-back writes to X7, then read X7 on port 0.
  - Required: fwd_sel[0] = 1 (youngest).
  - Stimulus: write X31, then read X31.
  - Required: fwd_sel = 0.
- **rd_used = 0.**
  - Stimulus: read an address matching an EX writer with rd_used[2] = 0.
  - Required: fwd_sel[2] = 0.
  - Stimulus: same with a load writer.
  - Required: stall = 0.
- **Flags.**
  - Stimulus: issue SUBS, next cycle issue B.cond.
  - Required: flag_fwd = 1.
  - Stimulus: SUBS, then a bubble cycle, then B.cond.
  - Required: flag_fwd = 0.
- **Flush and reset.**
  - Stimulus: load-use hazard cycle with flush = 1.
  - Required: stall = 0 and stage 1 stays empty (subsequent fwd_sel = 0 for that dest).
  - Stimulus: assert reset mid-stall.
  - Required: stall = 0, all fwd_sel = 0, stall_cycles = 0 without waiting for a clock edge.
